// File: rtl/mips_exec_core_if.sv
// Bus bundle for mips_exec_core: the instruction-memory port, run control/status and the debug register read port.
interface mips_exec_core_if #(
    parameter int PC_W = 3
);
    logic            start;
    logic [31:0]     instr;
    logic [PC_W-1:0] counter;
    logic            busy;
    logic            done;
    logic            illegal;
    logic [4:0]      dbg_addr;
    logic [31:0]     dbg_data;

    modport master (
        input  start, instr, dbg_addr,
        output counter, busy, done, illegal, dbg_data
    );

    modport slave (
        output start, instr, dbg_addr,
        input  counter, busy, done, illegal, dbg_data
    );
endinterface

// File: rtl/mips_exec_core.sv
// Multi-cycle (FETCH/DECODE/EXEC/WB) sequencer for addiu/addu/subu with a 32x32 register file.
// Build option: define SLT_EN to also decode slt/sltu.
module mips_exec_core #(
    parameter int PC_W      = 3,
    parameter int NUM_INSTR = 7
) (
    input logic              clk,
    input logic              rst,
    mips_exec_core_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_SLT, OP_SLTU} op_t;

    localparam logic [PC_W:0] NUM_INSTR_W = (PC_W+1)'(NUM_INSTR);

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W:0]   pc_inc_wide;
    logic [31:0]     ir_reg, a_reg, b_reg, alu_reg, dbg_data_reg;
    logic [4:0]      dest_reg;
    op_t             op_reg;
    logic            legal_reg, illegal_reg;
    logic            busy, done;

    logic [31:0]     regs [32];
    logic [31:0]     wr_sel;
    logic            wr_en;
    logic [31:0]     rs_data, rt_data, dbg_rd;

    logic [5:0]      opcode, funct;
    logic            dec_legal, dec_rtype;
    op_t             dec_op;

    assign opcode = ir_reg[31:26];
    assign funct  = ir_reg[5:0];

    always_comb begin
        dec_legal = 1'b0;
        dec_rtype = 1'b0;
        dec_op    = OP_ADD;
        if (opcode == 6'b001001) begin
            dec_legal = 1'b1;
        end else if (opcode == 6'b000000) begin
            dec_rtype = 1'b1;
            case (funct)
                6'b100001: dec_legal = 1'b1;
                6'b100011: begin dec_legal = 1'b1; dec_op = OP_SUB;  end
`ifdef SLT_EN
                6'b101010: begin dec_legal = 1'b1; dec_op = OP_SLT;  end
                6'b101011: begin dec_legal = 1'b1; dec_op = OP_SLTU; end
`endif
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // Register 0 is hard-wired to zero on every read port.
    assign rs_data = (ir_reg[25:21] == 5'd0) ? 32'd0 : regs[ir_reg[25:21]];
    assign rt_data = (ir_reg[20:16] == 5'd0) ? 32'd0 : regs[ir_reg[20:16]];
    assign dbg_rd  = (bus.dbg_addr == 5'd0)  ? 32'd0 : regs[bus.dbg_addr];

    assign pc_inc_wide = {1'b0, pc_reg} + (PC_W+1)'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (bus.start) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = (pc_inc_wide == NUM_INSTR_W) ? S_HALT : S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        wr_en = 1'b0;
        case (state_reg)
            S_FETCH, S_DECODE, S_EXEC: busy = 1'b1;
            S_WB: begin
                busy  = 1'b1;
                wr_en = legal_reg && (dest_reg != 5'd0);
            end
            S_HALT:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= '0;
            ir_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            alu_reg      <= '0;
            dest_reg     <= '0;
            op_reg       <= OP_ADD;
            legal_reg    <= 1'b0;
            illegal_reg  <= 1'b0;
            dbg_data_reg <= '0;
        end else begin
            dbg_data_reg <= dbg_rd;
            case (state_reg)
                S_FETCH: ir_reg <= bus.instr;
                S_DECODE: begin
                    a_reg     <= rs_data;
                    b_reg     <= dec_rtype ? rt_data : {{16{ir_reg[15]}}, ir_reg[15:0]};
                    dest_reg  <= dec_rtype ? ir_reg[15:11] : ir_reg[20:16];
                    op_reg    <= dec_op;
                    legal_reg <= dec_legal;
                end
                S_EXEC: begin
                    case (op_reg)
                        OP_ADD:  alu_reg <= a_reg + b_reg;
                        OP_SUB:  alu_reg <= a_reg - b_reg;
                        OP_SLT:  alu_reg <= {31'd0, $signed(a_reg) < $signed(b_reg)};
                        OP_SLTU: alu_reg <= {31'd0, a_reg < b_reg};
                        default: alu_reg <= '0;
                    endcase
                end
                S_WB: begin
                    // Advances even past an illegal word so the program still runs to HALT.
                    pc_reg <= pc_inc_wide[PC_W-1:0];
                    if (!legal_reg) illegal_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (dest_reg == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (rst)            regs[i] <= '0;
            else if (wr_sel[i]) regs[i] <= alu_reg;
        end
    end

    assign bus.counter  = pc_reg;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.illegal  = illegal_reg;
    assign bus.dbg_data = dbg_data_reg;
endmodule
